// File: rtl/mist_spi_pkg.sv
// ============================================================================
// Module   : mist_spi_pkg
// Purpose  : Shared definitions for the MiST user_io SPI command master:
//            FSM state encoding and the user_io command opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mist_spi_pkg;

    // FSM state encoding (explicit width so the states stay stable across builds).
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // user_io command opcodes.
    localparam logic [7:0] UIO_STATUS     = 8'h00;
    localparam logic [7:0] UIO_BUT_SW     = 8'h01;
    localparam logic [7:0] UIO_JOYSTICK0  = 8'h02;
    localparam logic [7:0] UIO_JOYSTICK1  = 8'h03;
    localparam logic [7:0] UIO_MOUSE      = 8'h04;
    localparam logic [7:0] UIO_KEYBOARD   = 8'h05;
    localparam logic [7:0] UIO_KBD_OSD    = 8'h06;
    localparam logic [7:0] UIO_GET_STRING = 8'h14;
    localparam logic [7:0] UIO_SET_STATUS = 8'h15;
    localparam logic [7:0] UIO_GET_SDSTAT = 8'h16;

endpackage

`default_nettype wire

// File: rtl/mist_spi_clkgen.sv
// ============================================================================
// Module   : mist_spi_clkgen
// Purpose  : Half-period counter for the SPI master. Counts CLK_DIV cycles
//            while cnt_en_i is high and, while sck_en_i is high, toggles SCK
//            at each wrap and flags the cycle before each edge.
// Ports    : clk_sys, reset   - clock / async active-high reset
//            cnt_en_i         - run the half-period counter
//            sck_en_i         - allow SCK toggling (SCK forced low otherwise)
//            tick_o           - counter at its last count this cycle
//            sck_rise_o/fall_o- SCK will rise/fall at the next clock edge
//            sck_o            - registered SCK level
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mist_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic cnt_en_i,
    input  logic sck_en_i,
    output logic tick_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic sck_o
);

    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    assign tick_o     = cnt_en_i && (cnt_q == CNT_MAX);
    assign sck_rise_o = tick_o && sck_en_i && !sck_q;
    assign sck_fall_o = tick_o && sck_en_i &&  sck_q;
    assign sck_o      = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!cnt_en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (!sck_en_i) begin
            sck_d = 1'b0;
        end else if (tick_o) begin
            sck_d = !sck_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mist_spi_cmd_master.sv
// ============================================================================
// Module   : mist_spi_cmd_master
// Purpose  : SPI initiator for the MiST user_io command protocol (IO
//            controller side). Sends one command byte followed by cmd_len
//            payload bytes, mode 0, MSB first; every byte shifted in from
//            the responder is returned on rx_data/rx_valid.
// Ports    : clk_sys, reset                 - clock / async active-high reset
//            cmd_valid/ready, cmd_byte/len  - frame request
//            tx_valid/ready, tx_data        - payload byte stream
//            rx_valid, rx_data, rx_cmd      - received bytes (rx_cmd marks
//                                             the command-byte slot)
//            busy                           - frame in progress
//            spi_ss_n/sck/mosi/miso         - SPI pins
// Config   : MIST_SPI_BYTE_GAP_EN - insert at least GAP_CYC idle cycles
//            (SCK low, SS low) between bytes of a frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mist_spi_cmd_master
    import mist_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic [7:0] cmd_len,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_cmd,
    output logic       busy,
    output logic       spi_ss_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    generate
        if (CLK_DIV < 2 || GAP_CYC < 1) begin : g_param_check
            $error("mist_spi_cmd_master: CLK_DIV must be >= 2 and GAP_CYC >= 1");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_cmd_q, rx_cmd_d;
    logic       ss_n_q, ss_n_d;
    logic       first_q, first_d;       // current byte is the command slot
    logic       tx_ready_d;

`ifdef MIST_SPI_BYTE_GAP_EN
    localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic w_tick, w_rise, w_fall, w_sck;
    logic w_cnt_en, w_sck_en;

    assign w_cnt_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    assign w_sck_en = (state_q == ST_SHIFT);

    mist_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cnt_en_i   (w_cnt_en),
        .sck_en_i   (w_sck_en),
        .tick_o     (w_tick),
        .sck_rise_o (w_rise),
        .sck_fall_o (w_fall),
        .sck_o      (w_sck)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_cmd_d    = 1'b0;
        ss_n_d      = ss_n_q;
        first_d     = first_q;
        tx_ready_d  = 1'b0;
`ifdef MIST_SPI_BYTE_GAP_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tx_sh_d     = cmd_byte;
                    remaining_d = cmd_len;
                    ss_n_d      = 1'b0;
                    first_d     = 1'b1;
                    bit_cnt_d   = 3'd0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    rx_sh_d = {rx_sh_q[6:0], spi_miso};
                end
                if (w_fall) begin
                    // MOSI is tx_sh_q[7]; shifting on the fall presents the next bit.
                    tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                        rx_cmd_d   = first_q;
                        first_d    = 1'b0;
                        if (remaining_q == 8'd0) begin
                            ss_n_d  = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
`ifdef MIST_SPI_BYTE_GAP_EN
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
`else
                            // Back-to-back: the next byte loads on this same fall.
                            if (tx_valid) begin
                                tx_ready_d  = 1'b1;
                                tx_sh_d     = tx_data;
                                remaining_d = remaining_q - 8'd1;
                            end else begin
                                state_d = ST_GAP;
                            end
`endif
                        end
                    end
                end
            end
            ST_GAP: begin
`ifdef MIST_SPI_BYTE_GAP_EN
                if (gap_cnt_q != GAP_LAST) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end else if (tx_valid) begin
                    tx_ready_d  = 1'b1;
                    tx_sh_d     = tx_data;
                    remaining_d = remaining_q - 8'd1;
                    state_d     = ST_SHIFT;
                end
`else
                if (tx_valid) begin
                    tx_ready_d  = 1'b1;
                    tx_sh_d     = tx_data;
                    remaining_d = remaining_q - 8'd1;
                    state_d     = ST_SHIFT;
                end
`endif
            end
            ST_HOLD: begin
                if (w_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            tx_sh_q     <= 8'd0;
            rx_sh_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_cmd_q    <= 1'b0;
            ss_n_q      <= 1'b1;
            first_q     <= 1'b0;
`ifdef MIST_SPI_BYTE_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_cmd_q    <= rx_cmd_d;
            ss_n_q      <= ss_n_d;
            first_q     <= first_d;
`ifdef MIST_SPI_BYTE_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    // cmd_ready is gated by reset so it reads 0 while reset is held.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign tx_ready  = tx_ready_d;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_cmd    = rx_cmd_q;
    assign busy      = (state_q != ST_IDLE);
    assign spi_ss_n  = ss_n_q;
    assign spi_sck   = w_sck;
    assign spi_mosi  = tx_sh_q[7];

endmodule

`default_nettype wire

// File: tb/tb_mist_spi_cmd_master.sv
// ============================================================================
// Module   : tb_mist_spi_cmd_master
// Purpose  : Self-checking bench for mist_spi_cmd_master with a mode-0 SPI
//            responder model, a payload driver and a scoreboard monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mist_spi_cmd_master;
    import mist_spi_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 8;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = 8'h00;
    logic [7:0] cmd_len  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data  = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_cmd;
    logic       busy;
    logic       spi_ss_n, spi_sck, spi_mosi;
    logic       spi_miso = 1'b0;

    always #5 clk_sys = ~clk_sys;

    mist_spi_cmd_master #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_byte  (cmd_byte),
        .cmd_len   (cmd_len),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_cmd    (rx_cmd),
        .busy      (busy),
        .spi_ss_n  (spi_ss_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        n_checks++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
        end
    endtask

    // Scoreboard queues: {rx_cmd, rx_data} and MOSI bytes, plus model data.
    logic [8:0] exp_rx[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] rsp_q[$];
    logic [7:0] tx_q[$];
    bit         tx_en = 1'b0;
    bit         took  = 1'b0;

    // Monitor / responder state.
    int rx_cnt = 0, txr_cnt = 0, viol = 0, frames = 0;
    int ss_low = 0, ss_high = 0, last_ss_high = 0, rises = 0;
    int lowrun = 0, maxlow = 0, nlong = 0, minlong = 0;
    int busy_lag = 0, r_bit = 0;
    bit seen_rise = 1'b0, busy_meas = 1'b0;
    logic prev_ss = 1'b1, prev_sck = 1'b0;
    logic [7:0] r_byte = 8'h00, r_acc = 8'h00;
    logic [8:0] sb_e;

    // Payload driver: updates tx_valid/tx_data just after the active edge.
    always @(posedge clk_sys) begin
        #1;
        if (took) begin
            took = 1'b0;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
        if (tx_en && tx_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = tx_q[0];
        end else begin
            tx_valid = 1'b0;
        end
    end

    always @(negedge clk_sys) begin
        // Scoreboard
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %02h expected none", rx_data);
            end else begin
                sb_e = exp_rx.pop_front();
                chk("rx_data", 32'(rx_data), 32'(sb_e[7:0]));
                chk("rx_cmd", 32'(rx_cmd), 32'(sb_e[8]));
            end
        end
        if (tx_ready) begin
            txr_cnt++;
            took = 1'b1;
        end
        if (cmd_ready && busy) viol++;

        // Frame timing metrics
        if (!spi_ss_n) begin
            if (prev_ss) begin
                ss_low = 0; rises = 0; lowrun = 0; seen_rise = 1'b0;
                maxlow = 0; nlong = 0; minlong = 100000;
                if (frames > 0) last_ss_high = ss_high;
                frames++;
            end
            ss_low++;
            if (spi_sck && !prev_sck) begin
                rises++;
                if (seen_rise) begin
                    if (lowrun > maxlow) maxlow = lowrun;
                    if (lowrun > CLK_DIV) begin
                        nlong++;
                        if (lowrun < minlong) minlong = lowrun;
                    end
                end
                seen_rise = 1'b1;
                lowrun = 0;
            end else if (!spi_sck) begin
                lowrun++;
            end
        end else begin
            if (!prev_ss) begin
                ss_high = 0; busy_meas = 1'b1; busy_lag = 0;
            end
            ss_high++;
        end
        if (busy_meas) begin
            if (busy) busy_lag++;
            else busy_meas = 1'b0;
        end

        // Mode-0 responder: MISO changes after SS fall / SCK fall, MOSI read at SCK rise.
        if (!spi_ss_n && prev_ss) begin
            r_byte   = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
            r_bit    = 0;
            r_acc    = 8'h00;
            spi_miso = r_byte[7];
        end else if (!spi_ss_n) begin
            if (spi_sck && !prev_sck) begin
                r_acc = {r_acc[6:0], spi_mosi};
                r_bit++;
                if (r_bit == 8) begin
                    if (exp_mosi.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mosi_unexpected: got %02h expected none", r_acc);
                    end else begin
                        chk("mosi_byte", 32'(r_acc), 32'(exp_mosi.pop_front()));
                    end
                end
            end else if (!spi_sck && prev_sck) begin
                if (r_bit == 8) begin
                    r_byte   = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
                    r_bit    = 0;
                    spi_miso = r_byte[7];
                end else begin
                    spi_miso = r_byte[7 - r_bit];
                end
            end
        end
        if (spi_ss_n) r_bit = 0;

        prev_ss  = spi_ss_n;
        prev_sck = spi_sck;
    end

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] l);
        bit ok = 1'b0;
        @(negedge clk_sys);
        cmd_byte  = c;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        chk("cmd_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk_sys);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_sys);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        @(negedge clk_sys);
    endtask

    task automatic clear_counts();
        rx_cnt  = 0;
        txr_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int f0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_ss_n", 32'(spi_ss_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_cmd", 32'(rx_cmd), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1) cmd 14, len 2, payload ready
        clear_counts();
        rsp_q = '{8'h01, 8'h02, 8'h03};
        exp_rx = '{{1'b1, 8'h01}, {1'b0, 8'h02}, {1'b0, 8'h03}};
        exp_mosi = '{8'h14, 8'hA5, 8'h3C};
        tx_q = '{8'hA5, 8'h3C};
        tx_en = 1'b1;
        send_cmd(UIO_GET_STRING, 8'd2);
        wait_idle("t1_done_timeout");
        chk("t1_rx_count", 32'(rx_cnt), 32'd3);
        chk("t1_tx_ready_count", 32'(txr_cnt), 32'd2);
        chk("t1_sck_rises", 32'(rises), 32'd24);
        chk("t1_busy_lag", 32'(busy_lag), 32'd2);
`ifndef MIST_SPI_BYTE_GAP_EN
        chk("t1_ss_low_cycles", 32'(ss_low), 32'd98);
        chk("t1_max_low", 32'(maxlow), 32'(CLK_DIV));
`endif
        chk("t1_rx_left", 32'(exp_rx.size()), 32'd0);
        chk("t1_mosi_left", 32'(exp_mosi.size()), 32'd0);

        // 2) len 0, cmd FF
        clear_counts();
        rsp_q = '{8'hAA};
        exp_rx = '{{1'b1, 8'hAA}};
        exp_mosi = '{8'hFF};
        send_cmd(8'hFF, 8'd0);
        wait_idle("t2_done_timeout");
        chk("t2_sck_rises", 32'(rises), 32'd8);
        chk("t2_rx_count", 32'(rx_cnt), 32'd1);
        chk("t2_tx_ready_count", 32'(txr_cnt), 32'd0);
        chk("t2_ss_low_cycles", 32'(ss_low), 32'd34);

        // 3) len 1, tx_valid withheld 50 cycles after the command byte
        clear_counts();
        tx_en = 1'b0;
        tx_q = '{8'h5A};
        rsp_q = '{8'h81, 8'h7E};
        exp_rx = '{{1'b1, 8'h81}, {1'b0, 8'h7E}};
        exp_mosi = '{UIO_SET_STATUS, 8'h5A};
        send_cmd(UIO_SET_STATUS, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys);
            if (rx_cnt >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t3_cmd_byte_timeout", 32'(ok), 32'd1);
        repeat (50) @(negedge clk_sys);
        chk("t3_wait_sck_low", 32'(spi_sck), 32'd0);
        chk("t3_wait_ss_low", 32'(spi_ss_n), 32'd0);
        tx_en = 1'b1;
        wait_idle("t3_done_timeout");
        chk("t3_long_gaps", 32'(nlong), 32'd1);
        chk_ge("t3_gap_len", minlong, 50);
        chk("t3_rx_count", 32'(rx_cnt), 32'd2);
        chk("t3_sck_rises", 32'(rises), 32'd16);
        chk("t3_tx_ready_count", 32'(txr_cnt), 32'd1);

        // 4) reset at bit 4 of the payload, then a normal frame
        clear_counts();
        tx_q = '{8'hC3};
        rsp_q = '{8'h11, 8'h22};
        exp_rx = '{{1'b1, 8'h11}, {1'b0, 8'h22}};
        exp_mosi = '{UIO_GET_SDSTAT, 8'hC3};
        send_cmd(UIO_GET_SDSTAT, 8'd1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys);
            if (rx_cnt == 1 && r_bit == 4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_bit4_timeout", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_ss_n", 32'(spi_ss_n), 32'd1);
        chk("t4_rst_sck", 32'(spi_sck), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("t4_no_rx_after_reset", 32'(rx_cnt), 32'd1);
        chk("t4_rx_pending", 32'(exp_rx.size()), 32'd1);
        chk("t4_mosi_pending", 32'(exp_mosi.size()), 32'd1);
        exp_rx.delete();
        exp_mosi.delete();
        tx_q.delete();
        rsp_q.delete();

        clear_counts();
        tx_q = '{8'h99};
        rsp_q = '{8'h33, 8'h44};
        exp_rx = '{{1'b1, 8'h33}, {1'b0, 8'h44}};
        exp_mosi = '{UIO_JOYSTICK0, 8'h99};
        send_cmd(UIO_JOYSTICK0, 8'd1);
        wait_idle("t4b_done_timeout");
        chk("t4b_rx_count", 32'(rx_cnt), 32'd2);
`ifndef MIST_SPI_BYTE_GAP_EN
        chk("t4b_ss_low_cycles", 32'(ss_low), 32'd66);
`endif

        // 5) len 3: inter-byte SCK-low intervals
        clear_counts();
        tx_q = '{8'h10, 8'h20, 8'h30};
        rsp_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        exp_rx = '{{1'b1, 8'h55}, {1'b0, 8'h66}, {1'b0, 8'h77}, {1'b0, 8'h88}};
        exp_mosi = '{UIO_KEYBOARD, 8'h10, 8'h20, 8'h30};
        send_cmd(UIO_KEYBOARD, 8'd3);
        wait_idle("t5_done_timeout");
        chk("t5_sck_rises", 32'(rises), 32'd32);
        chk("t5_rx_count", 32'(rx_cnt), 32'd4);
`ifdef MIST_SPI_BYTE_GAP_EN
        chk("t5_long_gaps", 32'(nlong), 32'd3);
        chk_ge("t5_gap_len", minlong, GAP_CYC + CLK_DIV);
`else
        chk("t5_long_gaps", 32'(nlong), 32'd0);
        chk("t5_max_low", 32'(maxlow), 32'(CLK_DIV));
        chk("t5_ss_low_cycles", 32'(ss_low), 32'd130);
`endif

        // 6) cmd_valid held across two frames
        clear_counts();
        viol = 0;
        rsp_q = '{8'h0F, 8'hF0};
        exp_rx = '{{1'b1, 8'h0F}, {1'b1, 8'hF0}};
        exp_mosi = '{UIO_JOYSTICK1, UIO_JOYSTICK1};
        f0 = frames;
        @(negedge clk_sys);
        cmd_byte  = UIO_JOYSTICK1;
        cmd_len   = 8'd0;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys);
            if (frames == f0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_second_frame_timeout", 32'(ok), 32'd1);
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        wait_idle("t6_done_timeout");
        chk_ge("t6_ss_high_between", last_ss_high, CLK_DIV);
        chk("t6_rx_count", 32'(rx_cnt), 32'd2);
        chk("t6_ready_while_busy", 32'(viol), 32'd0);
        chk("t6_rx_left", 32'(exp_rx.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
